// File: rtl/mem_bus_arbiter_if.sv
// Simplified single-beat AXI-style memory bus (read ar/r, write aw/w/b), 32-bit.
// Latency: none; this is wiring only.
// Backpressure: standard valid/ready on every channel; the slave may hold any ready low.
interface mem_bus_arbiter_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises inst/data cache single-word requests onto one AXI-style master, one transaction at a time.
// Latency: best-case read 4 cycles from req (grant, ar, r, dok); valids rise 1 cycle after grant.
// Backpressure: caches hold req until dok; every bus channel waits indefinitely on its ready/valid.
module mem_bus_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_req,
    input  logic [31:0]          inst_addr,
    output logic [31:0]          inst_rdata,
    output logic                 inst_dok,
    input  logic                 data_req,
    input  logic                 data_wr,
    input  logic [3:0]           data_wstrb,
    input  logic [31:0]          data_addr,
    input  logic [31:0]          data_wdata,
    output logic [31:0]          data_rdata,
    output logic                 data_dok,
    mem_bus_arbiter_if.master    bus
);

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    // owner_q: 1 = data cache, 0 = inst cache. The read/write direction of the
    // granted request is carried by the RADDR/WADDR branch of the FSM itself.
    logic        owner_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;

    logic        grant_any;
    logic        grant_data;
    logic        ar_vld;
    logic        r_rdy;
    logic        aw_vld;
    logic        w_vld;
    logic        b_rdy;
    logic        r_hs;
    logic        aw_hs;
    logic        w_hs;

    assign grant_any  = inst_req | data_req;
    assign grant_data = data_req & (DATA_FIRST | ~inst_req);

    assign r_hs  = r_rdy  & bus.rvalid;
    assign aw_hs = aw_vld & bus.awready;
    assign w_hs  = w_vld  & bus.wready;

    assign bus.araddr  = addr_q;
    assign bus.awaddr  = addr_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.arvalid = ar_vld;
    assign bus.rready  = r_rdy;
    assign bus.awvalid = aw_vld;
    assign bus.wvalid  = w_vld;
    assign bus.bready  = b_rdy;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state bus/handshake outputs.
    always_comb begin
        state_nxt = state;
        ar_vld    = 1'b0;
        r_rdy     = 1'b0;
        aw_vld    = 1'b0;
        w_vld     = 1'b0;
        b_rdy     = 1'b0;
        inst_dok  = 1'b0;
        data_dok  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = (grant_data && data_wr) ? WADDR : RADDR;
                end
            end
            RADDR: begin
                ar_vld = 1'b1;
                if (bus.arready) begin
                    state_nxt = RDATA;
                end
            end
            RDATA: begin
                r_rdy = 1'b1;
                if (bus.rvalid) begin
                    state_nxt = DONE;
                end
            end
            WADDR: begin
                // aw and w each drop independently once their own handshake is done.
                aw_vld = ~aw_done;
                w_vld  = ~w_done;
                if ((aw_done || bus.awready) && (w_done || bus.wready)) begin
                    state_nxt = WRESP;
                end
            end
            WRESP: begin
                b_rdy = 1'b1;
                if (bus.bvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                inst_dok  = ~owner_q;
                data_dok  = owner_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant-time attribute latch, write-channel completion flags and read data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            inst_rdata <= 32'h0;
            data_rdata <= 32'h0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner_q <= grant_data;
                addr_q  <= grant_data ? data_addr : inst_addr;
                wdata_q <= grant_data ? data_wdata : 32'h0;
                wstrb_q <= grant_data ? data_wstrb : 4'h0;
            end
            if (state == WADDR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (r_hs) begin
                if (owner_q) data_rdata <= bus.rdata;
                else         inst_rdata <= bus.rdata;
            end
        end
    end

endmodule
